fetch_controller: RTL and testbench

- Sequences the IF stage. Owns the fetch PC and issues word requests to the instruction memory over a req/ack handshake.
- Buffers returned instructions in a small queue and presents them to decode with their PC and next-PC.
- Handles decode stalls, branch redirects (flush plus discard of an in-flight response) and end-of-program halt.

---
 rtl/fetch_controller.sv | 214 +++++++++++++++++++++
 tb/tb_fetch_controller.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_controller.sv
// -----------------------------------------------------------------------------
// fetch_controller
//
// Instruction-fetch sequencer. Owns the fetch PC, issues one word request at a
// time to instruction memory over a req/ack handshake, buffers returned words
// in a small FIFO and presents the head entry to decode together with its PC
// and next PC. Handles decode stalls, branch redirects (flush, plus discard of
// a response that was already in flight) and a halt at a fixed end address.
//
// Ports
//   clk          rising-edge clock
//   reset        synchronous, active-low reset
//   imem_req     request to instruction memory (registered)
//   imem_addr    byte address of the requested word (registered)
//   imem_ack     memory response; imem_rdata is valid in this cycle
//   imem_rdata   returned instruction word
//   stall_flag   decode cannot accept; the queue head is held
//   br_taken     one-cycle redirect pulse from the branch unit
//   br_target    redirect address (low two bits ignored)
//   if_valid     queue head valid to decode
//   if_instn     head instruction (0 when if_valid=0)
//   if_pc        head instruction's PC (0 when if_valid=0)
//   if_nextpc    if_pc + 4 (0 when if_valid=0)
//   queue_count  queue occupancy
//   halted       fetching stopped at HALT_PC
// -----------------------------------------------------------------------------
module fetch_controller #(
    parameter logic [31:0] RESET_PC = 32'd0,
    parameter logic [31:0] HALT_PC  = 32'd48,
    parameter int unsigned QDEPTH   = 2
) (
    input  logic                      clk,
    input  logic                      reset,
    output logic                      imem_req,
    output logic [31:0]               imem_addr,
    input  logic                      imem_ack,
    input  logic [31:0]               imem_rdata,
    input  logic                      stall_flag,
    input  logic                      br_taken,
    input  logic [31:0]               br_target,
    output logic                      if_valid,
    output logic [31:0]               if_instn,
    output logic [31:0]               if_pc,
    output logic [31:0]               if_nextpc,
    output logic [$clog2(QDEPTH):0]   queue_count,
    output logic                      halted
);

    localparam int unsigned PTR_W = $clog2(QDEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(QDEPTH);

    // ST_DRAIN doubles as the "discard the pending response" flag: the only
    // way to be there is a redirect that abandoned an outstanding request.
    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_HALT  = 2'd2
    } state_t;

    state_t           state_q,    state_d;
    logic [31:0]      fetch_pc_q, fetch_pc_d;
    logic             req_q,      req_d;
    logic [31:0]      addr_q,     addr_d;
    logic [PTR_W-1:0] rd_ptr_q,   rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q,   wr_ptr_d;
    logic [CNT_W-1:0] count_q,    count_d;

    // Queue storage carries data only, so it is not reset; count_q alone
    // decides which entries are meaningful.
    logic [31:0]      instn_q [QDEPTH];
    logic [31:0]      instn_d [QDEPTH];
    logic [31:0]      qpc_q   [QDEPTH];
    logic [31:0]      qpc_d   [QDEPTH];

    logic             q_empty;
    logic             ack_seen;
    logic             do_push;
    logic             do_pop;

    // -------------------------------------------------------------------------
    // Next-state / datapath
    // -------------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        req_d      = req_q;
        addr_d     = addr_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        instn_d    = instn_q;
        qpc_d      = qpc_q;

        q_empty  = (count_q == '0);
        // An ack with nothing outstanding (e.g. left over from before a
        // reset) is meaningless and must not be consumed.
        ack_seen = req_q && imem_ack;
        do_push  = 1'b0;
        do_pop   = !q_empty && !stall_flag && !br_taken;

        if (br_taken) begin
            // Redirect wins over everything: flush, retarget, and either
            // wait out the abandoned request or go straight back to RUN.
            fetch_pc_d = br_target & 32'hFFFF_FFFC;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            count_d    = '0;
            if (req_q && !imem_ack) begin
                state_d = ST_DRAIN;
            end else begin
                state_d = ST_RUN;
                req_d   = 1'b0;
            end
        end else begin
            unique case (state_q)
                ST_RUN: begin
                    if (ack_seen) begin
                        do_push    = 1'b1;
                        fetch_pc_d = fetch_pc_q + 32'd4;
                        req_d      = 1'b0;
                    end else if (!req_q && (count_q < FULL_CNT) &&
                                 (fetch_pc_q != HALT_PC)) begin
                        // Only issue when a slot is free for the reply, so
                        // a push can never hit a full queue.
                        req_d  = 1'b1;
                        addr_d = fetch_pc_q;
                    end else if (!req_q && q_empty &&
                                 (fetch_pc_q == HALT_PC)) begin
                        state_d = ST_HALT;
                    end
                end
                ST_DRAIN: begin
                    // Response to the abandoned address is dropped.
                    if (ack_seen) begin
                        req_d   = 1'b0;
                        state_d = ST_RUN;
                    end
                end
                ST_HALT: begin
                    state_d = ST_HALT;
                end
                default: begin
                    state_d = ST_RUN;
                end
            endcase

            if (do_push) begin
                instn_d[wr_ptr_q] = imem_rdata;
                qpc_d[wr_ptr_q]   = addr_q;
                wr_ptr_d          = wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            unique case ({do_push, do_pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Control registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= ST_RUN;
            fetch_pc_q <= RESET_PC;
            req_q      <= 1'b0;
            addr_q     <= RESET_PC;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            req_q      <= req_d;
            addr_q     <= addr_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
        end
    end

    // -------------------------------------------------------------------------
    // Queue storage
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        instn_q <= instn_d;
        qpc_q   <= qpc_d;
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    always_comb begin
        imem_req    = req_q;
        imem_addr   = addr_q;
        queue_count = count_q;
        halted      = (state_q == ST_HALT);
        if_valid    = !q_empty;
        if_instn    = 32'd0;
        if_pc       = 32'd0;
        if_nextpc   = 32'd0;
        if (!q_empty) begin
            if_instn  = instn_q[rd_ptr_q];
            if_pc     = qpc_q[rd_ptr_q];
            if_nextpc = qpc_q[rd_ptr_q] + 32'd4;
        end
    end

endmodule

// File: tb/tb_fetch_controller.sv
// -----------------------------------------------------------------------------
// tb_fetch_controller
//
// Bench for fetch_controller: a hand-derived vector table for reset, issue,
// stall fill, redirect and drain; directed sequences for halt, memory latency,
// stall release, reset during a request and restart from halt; then random
// traffic compared each cycle against a queue-based reference model.
// -----------------------------------------------------------------------------
module tb_fetch_controller;

    localparam logic [31:0] RESET_PC = 32'd0;
    localparam logic [31:0] HALT_PC  = 32'd48;
    localparam int unsigned QDEPTH   = 2;

    logic        clk;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        stall_flag;
    logic        br_taken;
    logic [31:0] br_target;
    logic        if_valid;
    logic [31:0] if_instn;
    logic [31:0] if_pc;
    logic [31:0] if_nextpc;
    logic [1:0]  queue_count;
    logic        halted;

    fetch_controller #(
        .RESET_PC(RESET_PC),
        .HALT_PC (HALT_PC),
        .QDEPTH  (QDEPTH)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .stall_flag (stall_flag),
        .br_taken   (br_taken),
        .br_target  (br_target),
        .if_valid   (if_valid),
        .if_instn   (if_instn),
        .if_pc      (if_pc),
        .if_nextpc  (if_nextpc),
        .queue_count(queue_count),
        .halted     (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_miss = 0;

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
        end
    endfunction

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'd7) ^ 32'h1357_9BDF;
    endfunction

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [31:0] instn;
        logic [31:0] pc;
    } ent_t;

    ent_t        mq[$];
    int          m_mode;   // 0 fetching, 1 waiting to discard, 2 halted
    logic [31:0] m_pc;
    logic [31:0] m_addr;
    bit          m_out;

    function automatic void model_step(input bit rst_n, input bit ack, input logic [31:0] rdata,
                                       input bit stl, input bit brt, input logic [31:0] tgt);
        int          cnt0;
        bit          out0;
        logic [31:0] pc0;
        ent_t        e;
        if (!rst_n) begin
            m_mode = 0; m_pc = RESET_PC; mq.delete(); m_out = 0; m_addr = RESET_PC;
            return;
        end
        cnt0 = mq.size(); out0 = m_out; pc0 = m_pc;
        if (brt) begin
            mq.delete();
            m_pc = tgt & ~32'd3;
            if (out0 && !ack) m_mode = 1;
            else begin m_mode = 0; m_out = 0; end
            return;
        end
        if (cnt0 > 0 && !stl) void'(mq.pop_front());
        if (m_mode == 1) begin
            if (ack) begin m_out = 0; m_mode = 0; end
        end else if (m_mode == 0) begin
            if (out0 && ack) begin
                e.instn = rdata; e.pc = m_addr;
                mq.push_back(e);
                m_pc  = pc0 + 32'd4;
                m_out = 0;
            end else if (!out0 && cnt0 < int'(QDEPTH) && pc0 != HALT_PC) begin
                m_out = 1; m_addr = pc0;
            end else if (!out0 && cnt0 == 0 && pc0 == HALT_PC) begin
                m_mode = 2;
            end
        end
    endfunction

    task automatic compare_all();
        bit v;
        v = (mq.size() > 0);
        chk("imem_req",    32'(imem_req),    32'(m_out));
        chk("imem_addr",   imem_addr,        m_addr);
        chk("if_valid",    32'(if_valid),    32'(v));
        chk("if_instn",    if_instn,         v ? mq[0].instn : 32'd0);
        chk("if_pc",       if_pc,            v ? mq[0].pc : 32'd0);
        chk("if_nextpc",   if_nextpc,        v ? mq[0].pc + 32'd4 : 32'd0);
        chk("queue_count", 32'(queue_count), 32'(mq.size()));
        chk("halted",      32'(halted),      32'(m_mode == 2));
    endtask

    // ---------------- memory responder + one clock cycle ----------------
    int mem_lat  = 0;
    int mem_wait = 0;
    bit rand_lat = 0;
    bit last_ack = 0;

    task automatic run_cycle(input bit rst_n, input bit stl, input bit brt,
                             input logic [31:0] tgt, input bit fack);
        bit          a;
        bit          req_pre;
        logic [31:0] rd;
        req_pre = imem_req;
        if (rand_lat && req_pre && mem_wait == 0) mem_lat = $urandom_range(0, 3);
        a = req_pre && (mem_wait >= mem_lat);
        if (fack) a = 1;
        rd = mem_word(imem_addr);
        reset = rst_n; stall_flag = stl; br_taken = brt; br_target = tgt;
        imem_ack = a; imem_rdata = rd;
        @(posedge clk);
        model_step(rst_n, a, rd, stl, brt, tgt);
        if (req_pre && !a) mem_wait++;
        else mem_wait = 0;
        last_ack = a;
        #1;
        compare_all();
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        bit          rst_n;
        bit          ack;
        bit          stl;
        bit          br;
        logic [31:0] tgt;
        bit          e_req;
        logic [31:0] e_addr;
        bit          e_valid;
        logic [31:0] e_pc;
        logic [7:0]  e_cnt;
        bit          e_halt;
    } vec_t;

    localparam int NV = 21;
    vec_t tv[NV];

    int          pops[$];
    logic [31:0] issued[$];
    int          hold;
    int          n48;
    bit          prev_req;
    logic [31:0] prev_addr;

    initial begin
        //            rst  ack  stl  br   tgt       req  addr      vld  pc        cnt  hlt
        tv[0]  = '{1'b0,1'b0,1'b0,1'b0,32'h00, 1'b0,32'h00, 1'b0,32'h00, 8'd0,1'b0};
        tv[1]  = '{1'b0,1'b1,1'b0,1'b1,32'h30, 1'b0,32'h00, 1'b0,32'h00, 8'd0,1'b0};
        tv[2]  = '{1'b1,1'b0,1'b0,1'b0,32'h00, 1'b1,32'h00, 1'b0,32'h00, 8'd0,1'b0};
        tv[3]  = '{1'b1,1'b1,1'b1,1'b0,32'h00, 1'b0,32'h00, 1'b1,32'h00, 8'd1,1'b0};
        tv[4]  = '{1'b1,1'b0,1'b1,1'b0,32'h00, 1'b1,32'h04, 1'b1,32'h00, 8'd1,1'b0};
        tv[5]  = '{1'b1,1'b1,1'b1,1'b0,32'h00, 1'b0,32'h04, 1'b1,32'h00, 8'd2,1'b0};
        tv[6]  = '{1'b1,1'b0,1'b1,1'b0,32'h00, 1'b0,32'h04, 1'b1,32'h00, 8'd2,1'b0};
        tv[7]  = '{1'b1,1'b0,1'b1,1'b0,32'h00, 1'b0,32'h04, 1'b1,32'h00, 8'd2,1'b0};
        tv[8]  = '{1'b1,1'b0,1'b0,1'b0,32'h00, 1'b0,32'h04, 1'b1,32'h04, 8'd1,1'b0};
        tv[9]  = '{1'b1,1'b0,1'b0,1'b0,32'h00, 1'b1,32'h08, 1'b0,32'h00, 8'd0,1'b0};
        tv[10] = '{1'b1,1'b1,1'b0,1'b0,32'h00, 1'b0,32'h08, 1'b1,32'h08, 8'd1,1'b0};
        tv[11] = '{1'b1,1'b0,1'b0,1'b1,32'h20, 1'b0,32'h08, 1'b0,32'h00, 8'd0,1'b0};
        tv[12] = '{1'b1,1'b0,1'b0,1'b0,32'h00, 1'b1,32'h20, 1'b0,32'h00, 8'd0,1'b0};
        tv[13] = '{1'b1,1'b0,1'b0,1'b1,32'h44, 1'b1,32'h20, 1'b0,32'h00, 8'd0,1'b0};
        tv[14] = '{1'b1,1'b0,1'b0,1'b0,32'h00, 1'b1,32'h20, 1'b0,32'h00, 8'd0,1'b0};
        tv[15] = '{1'b1,1'b1,1'b0,1'b0,32'h00, 1'b0,32'h20, 1'b0,32'h00, 8'd0,1'b0};
        tv[16] = '{1'b1,1'b0,1'b0,1'b0,32'h00, 1'b1,32'h44, 1'b0,32'h00, 8'd0,1'b0};
        tv[17] = '{1'b1,1'b1,1'b0,1'b1,32'h23, 1'b0,32'h44, 1'b0,32'h00, 8'd0,1'b0};
        tv[18] = '{1'b1,1'b0,1'b0,1'b0,32'h00, 1'b1,32'h20, 1'b0,32'h00, 8'd0,1'b0};
        tv[19] = '{1'b1,1'b1,1'b0,1'b0,32'h00, 1'b0,32'h20, 1'b1,32'h20, 8'd1,1'b0};
        tv[20] = '{1'b1,1'b0,1'b0,1'b0,32'h00, 1'b1,32'h24, 1'b0,32'h00, 8'd0,1'b0};

        reset = 1'b0; imem_ack = 1'b0; imem_rdata = 32'd0;
        stall_flag = 1'b0; br_taken = 1'b0; br_target = 32'd0;

        for (int i = 0; i < NV; i++) begin
            reset = tv[i].rst_n; imem_ack = tv[i].ack; stall_flag = tv[i].stl;
            br_taken = tv[i].br; br_target = tv[i].tgt;
            imem_rdata = mem_word(imem_addr);
            @(posedge clk);
            #1;
            chk($sformatf("tv%0d.imem_req", i),    32'(imem_req),    32'(tv[i].e_req));
            chk($sformatf("tv%0d.imem_addr", i),   imem_addr,        tv[i].e_addr);
            chk($sformatf("tv%0d.if_valid", i),    32'(if_valid),    32'(tv[i].e_valid));
            chk($sformatf("tv%0d.if_pc", i),       if_pc,            tv[i].e_pc);
            chk($sformatf("tv%0d.if_instn", i),    if_instn,
                tv[i].e_valid ? mem_word(tv[i].e_pc) : 32'd0);
            chk($sformatf("tv%0d.if_nextpc", i),   if_nextpc,
                tv[i].e_valid ? tv[i].e_pc + 32'd4 : 32'd0);
            chk($sformatf("tv%0d.queue_count", i), 32'(queue_count), 32'(tv[i].e_cnt));
            chk($sformatf("tv%0d.halted", i),      32'(halted),      32'(tv[i].e_halt));
        end

        // ---- zero-wait memory, run to halt ----
        mem_lat = 0; rand_lat = 0;
        run_cycle(0, 0, 0, 0, 0);
        prev_req = imem_req;
        for (int c = 0; c < 200 && !halted; c++) begin
            if (if_valid) pops.push_back(int'(if_pc));
            run_cycle(1, 0, 0, 0, 0);
            if (imem_req && !prev_req) issued.push_back(imem_addr);
            prev_req = imem_req;
        end
        chk("halt.reached", 32'(halted), 32'd1);
        chk("halt.pop_count", 32'(pops.size()), 32'd12);
        foreach (pops[i]) chk($sformatf("halt.pop%0d", i), 32'(pops[i]), 32'(4 * i));
        n48 = 0;
        foreach (issued[i]) if (issued[i] == HALT_PC) n48++;
        chk("halt.no_req_48", 32'(n48), 32'd0);
        for (int c = 0; c < 3; c++) begin
            run_cycle(1, 0, 0, 0, 0);
            chk("halt.req_low", 32'(imem_req), 32'd0);
            chk("halt.stays", 32'(halted), 32'd1);
        end
        run_cycle(1, 0, 1, 32'h10, 0);
        chk("halt.exit", 32'(halted), 32'd0);
        run_cycle(1, 0, 0, 0, 0);
        chk("halt.resume_req", 32'(imem_req), 32'd1);
        chk("halt.resume_addr", imem_addr, 32'h10);

        // ---- memory latency: req held 3 cycles per request ----
        pops.delete();
        mem_lat = 2;
        run_cycle(0, 0, 0, 0, 0);
        hold = 0;
        for (int c = 0; c < 60; c++) begin
            prev_req = imem_req; prev_addr = imem_addr;
            if (if_valid) pops.push_back(int'(if_pc));
            run_cycle(1, 0, 0, 0, 0);
            if (prev_req) hold++;
            if (prev_req && !last_ack) begin
                chk("lat.req_held", 32'(imem_req), 32'd1);
                chk("lat.addr_held", imem_addr, prev_addr);
            end
            if (last_ack) begin
                chk("lat.hold_len", 32'(hold), 32'd3);
                hold = 0;
            end
        end
        chk("lat.some_pops", 32'(pops.size() >= 6), 32'd1);
        foreach (pops[i]) chk($sformatf("lat.pop%0d", i), 32'(pops[i]), 32'(4 * i));

        // ---- stall fills queue, then release ----
        mem_lat = 0;
        run_cycle(0, 0, 0, 0, 0);
        for (int c = 0; c < 6; c++) run_cycle(1, 1, 0, 0, 0);
        chk("stall.count_full", 32'(queue_count), 32'(QDEPTH));
        chk("stall.no_req", 32'(imem_req), 32'd0);
        chk("stall.head_pc", if_pc, 32'h0);
        chk("stall.head_instn", if_instn, mem_word(32'h0));
        run_cycle(1, 0, 0, 0, 0);
        chk("stall.release_pc", if_pc, 32'h4);
        chk("stall.release_cnt", 32'(queue_count), 32'd1);

        // ---- reset during an outstanding request, stale ack afterwards ----
        mem_lat = 100;
        run_cycle(0, 0, 0, 0, 0);
        run_cycle(1, 0, 0, 0, 0);
        run_cycle(1, 0, 0, 0, 0);
        chk("rst.req_pending", 32'(imem_req), 32'd1);
        run_cycle(0, 0, 0, 0, 0);
        chk("rst.req_low", 32'(imem_req), 32'd0);
        chk("rst.addr", imem_addr, RESET_PC);
        chk("rst.valid", 32'(if_valid), 32'd0);
        chk("rst.halted", 32'(halted), 32'd0);
        run_cycle(1, 0, 0, 0, 1);
        chk("rst.stale_ignored_cnt", 32'(queue_count), 32'd0);
        chk("rst.restart_req", 32'(imem_req), 32'd1);
        chk("rst.restart_addr", imem_addr, RESET_PC);
        mem_lat = 0;
        for (int c = 0; c < 4; c++) run_cycle(1, 0, 0, 0, 0);

        // ---- random traffic against the model ----
        rand_lat = 1;
        run_cycle(0, 0, 0, 0, 0);
        for (int c = 0; c < 3000; c++) begin
            run_cycle($urandom_range(0, 99) != 0,
                      $urandom_range(0, 9) < 3,
                      $urandom_range(0, 99) < 4,
                      32'($urandom_range(0, 63)),
                      $urandom_range(0, 99) < 2);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
